// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// State encoding and default operand width.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational full-subtractor cell.
// Computes x - y - bi as one diff bit and a borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bout
);

  // Difference bit and borrow generation
  always_comb begin
    diff = x ^ y ^ bi;
    bout = (~x & y) | (~x & bi) | (y & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b, LSB first.
// One fs_cell, registered borrow, start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             bo_q, bo_d;
  logic             v_q, v_d;

  logic dbit;
  logic bnext;
  logic last;
  logic load;
  logic busy_o;
  logic done_o;

  fs_cell u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bi   (br_q),
    .diff (dbit),
    .bout (bnext)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  // Operand acceptance: only outside RUN
  always_comb begin
    load = start &
           ((state_q == IDLE) |
            (state_q == DONE));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = DONE;
      DONE: state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      RUN:  busy_o = 1'b1;
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: load, shift, complete
  always_comb begin
    sa_d  = sa_q;
    sb_d  = sb_q;
    sd_d  = sd_q;
    br_d  = br_q;
    cnt_d = cnt_q;
    am_d  = am_q;
    bm_d  = bm_q;
    d_d   = d_q;
    bo_d  = bo_q;
    v_d   = v_q;
    if (load) begin
      sa_d  = a;
      sb_d  = b;
      br_d  = 1'b0;
      cnt_d = '0;
      am_d  = a[WIDTH-1];
      bm_d  = b[WIDTH-1];
    end else if (state_q == RUN) begin
      sd_d  = {dbit, sd_q[WIDTH-1:1]};
      br_d  = bnext;
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        d_d  = {dbit, sd_q[WIDTH-1:1]};
        bo_d = bnext;
        v_d  = (am_q ^ bm_q) &
               (dbit ^ am_q);
      end
    end
  end

  // Datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q  <= '0;
      sb_q  <= '0;
      sd_q  <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      d_q   <= '0;
      bo_q  <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      sd_q  <= sd_d;
      br_q  <= br_d;
      cnt_q <= cnt_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
      d_q   <= d_d;
      bo_q  <= bo_d;
      v_q   <= v_d;
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign v    = v_q;
  assign busy = busy_o;
  assign done = done_o;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor and fs_cell.
// Directed plus random operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] d;
  logic         bo;
  logic         v;
  logic         busy;
  logic         done;

  logic fx = 1'b0;
  logic fy = 1'b0;
  logic fbi = 1'b0;
  logic fdiff;
  logic fbout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_d = '0;
  logic         exp_bo = 1'b0;
  logic         exp_v = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .d     (d),
    .bo    (bo),
    .v     (v),
    .busy  (busy),
    .done  (done)
  );

  fs_cell u_cell (
    .x    (fx),
    .y    (fy),
    .bi   (fbi),
    .diff (fdiff),
    .bout (fbout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic
  task automatic model(
    input logic [W-1:0] ma,
    input logic [W-1:0] mb
  );
    int ua;
    int ub;
    int sa;
    int sb;
    int sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = ua - ((ua >= 128) ? 256 : 0);
    sb = ub - ((ub >= 128) ? 256 : 0);
    sr = sa - sb;
    exp_d  = W'((ua - ub + 256) % 256);
    exp_bo = (ua < ub);
    exp_v  = (sr > 127) || (sr < -128);
  endtask

  // Issue one op; start must be accepted now.
  task automatic run_op(
    input logic [W-1:0] oa,
    input logic [W-1:0] ob,
    input bit           noise,
    input string        tag
  );
    logic [W-1:0] pd;
    logic         pbo;
    logic         pv;
    pd  = d;
    pbo = bo;
    pv  = v;
    start = 1'b1;
    a = oa;
    b = ob;
    tick();
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      if (i < W) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_nodone"}, 32'(done), 32'd0);
        check({tag, "_hold"},
              32'({pd, pbo, pv}),
              32'({d, bo, v}));
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (i < W) tick();
    end
    start = 1'b0;
    tick();
    model(oa, ob);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idlebusy"}, 32'(busy), 32'd0);
    check({tag, "_d"}, 32'(d), 32'(exp_d));
    check({tag, "_bo"}, 32'(bo), 32'(exp_bo));
    check({tag, "_v"}, 32'(v), 32'(exp_v));
  endtask

  initial begin
    // fs_cell exhaustive
    for (int k = 0; k < 8; k++) begin
      int r;
      fx  = k[2];
      fy  = k[1];
      fbi = k[0];
      #1;
      r = int'(fx) - int'(fy) - int'(fbi);
      check("cell_diff", 32'(fdiff), 32'(r & 1));
      check("cell_bout", 32'(fbout), 32'(r < 0));
    end

    rst = 1'b1;
    tick();
    tick();
    check("rst_out", 32'({d, bo, v, busy, done}), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    run_op(8'h35, 8'h12, 1'b0, "t1");
    check("t1_d_k", 32'(d), 32'h23);
    tick();
    check("t1_idle", 32'({busy, done}), 32'd0);

    run_op(8'h12, 8'h35, 1'b0, "t2a");
    check("t2a_k", 32'({d, bo, v}), 32'({8'hDD, 2'b10}));
    tick();
    run_op(8'h00, 8'h01, 1'b0, "t2b");
    check("t2b_k", 32'({d, bo, v}), 32'({8'hFF, 2'b10}));
    tick();
    run_op(8'h80, 8'h01, 1'b0, "t3a");
    check("t3a_k", 32'({d, bo, v}), 32'({8'h7F, 2'b01}));
    tick();
    run_op(8'h7F, 8'hFF, 1'b0, "t3b");
    check("t3b_k", 32'({d, bo, v}), 32'({8'h80, 2'b11}));
    tick();

    run_op(8'h5A, 8'hC3, 1'b1, "t4");
    tick();

    // Abort mid-run
    start = 1'b1;
    a = 8'h99;
    b = 8'h11;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst", 32'({d, bo, v, busy, done}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("t5_nodone", 32'(done), 32'd0);
      tick();
    end
    run_op(8'hAA, 8'h55, 1'b0, "t5");
    check("t5_k", 32'({d, bo, v}), 32'({8'h55, 2'b01}));

    // Back-to-back from the DONE cycle
    run_op(8'hF0, 8'h0F, 1'b0, "t6");
    check("t6_k", 32'({d, bo, v}), 32'({8'hE1, 2'b00}));
    tick();

    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), "rnd");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    check("end_idle", 32'({busy, done}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
